// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: memory-op encoding, load/store unit states and op decode helpers.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t LSU_IDLE = 2'd0;
  localparam lsu_state_t LSU_BUS  = 2'd1;
  localparam lsu_state_t LSU_RESP = 2'd2;

  // Encodings outside the enum decode as LW.
  function automatic logic is_load(input logic [3:0] op);
    return !(op == OP_SB || op == OP_SH || op == OP_SW);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_LB || op == OP_LH);
  endfunction

  function automatic mem_size_t op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Load data lane select and sign/zero extension (combinational).
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [3:0]  op,
  output logic [31:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b   = rdata[{a, 3'b000} +: 8];
    h   = rdata[{a[1], 4'b0000} +: 16];
    ext = rdata;
    case (op_size(op))
      SZ_BYTE: ext = is_signed(op) ? {{24{b[7]}}, b} : {24'd0, b};
      SZ_HALF: ext = is_signed(op) ? {{16{h[15]}}, h} : {16'd0, h};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// Load/store unit: one datapath request -> one Avalon-MM read/write with byte lanes.
// Build option: define ADDR_ERROR_EN to reject misaligned half/word accesses with resp_err.
module mips_cpu_load_store_unit
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int RESP_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata
);

  if (RESP_REG != 1 || ADDR_W != 32) begin : g_bad_cfg
    $error("mips_cpu_load_store_unit: only ADDR_W=32, RESP_REG=1 supported");
  end

  lsu_state_t  state;
  logic [3:0]  op_q;
  logic [1:0]  a_q;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic        mis;
  logic        accept;
  logic        done;
  logic [31:0] ld_ext;

  assign req_ready = (state == LSU_IDLE);
  assign accept    = req_valid && req_ready;
  assign done      = (avm_read || avm_write) && !avm_waitrequest;

  always_comb begin
    be_n = 4'b1111;
    wd_n = req_wdata;
    case (op_size(req_op))
      SZ_BYTE: begin
        be_n = 4'b0001 << req_addr[1:0];
        wd_n = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_n = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{req_wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = req_wdata;
      end
    endcase
  end

`ifdef ADDR_ERROR_EN
  assign mis = ((op_size(req_op) == SZ_HALF) && req_addr[0]) ||
               ((op_size(req_op) == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  mips_cpu_load_align u_align (
    .rdata (avm_readdata),
    .a     (a_q),
    .op    (op_q),
    .ext   (ld_ext)
  );

  // Request capture: op and lane offset only steer the load extract.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= req_op;
      a_q  <= req_addr[1:0];
    end
  end

  // Control and bus outputs; bus fields are zero whenever no strobe is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LSU_IDLE;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_err       <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= 4'd0;
      avm_writedata  <= 32'd0;
    end else begin
      case (state)
        LSU_IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          if (accept) begin
            if (mis) begin
              state      <= LSU_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state          <= LSU_BUS;
              avm_address    <= {req_addr[ADDR_W-1:2], 2'b00};
              avm_byteenable <= be_n;
              avm_writedata  <= wd_n;
              avm_read       <= is_load(req_op);
              avm_write      <= !is_load(req_op);
            end
          end
        end
        LSU_BUS: begin
          if (done) begin
            state          <= LSU_RESP;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= 4'd0;
            avm_writedata  <= 32'd0;
            resp_valid     <= 1'b1;
            resp_rdata     <= is_load(op_q) ? ld_ext : 32'd0;
          end
        end
        LSU_RESP: begin
          state      <= LSU_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
